// File: rtl/sipo_deserializer_8_bit_if.sv
// sipo_deserializer_8_bit_if: frame input, byte handshake and status signals of the deserializer.
interface sipo_deserializer_8_bit_if;
    logic       Frame_Start_In;
    logic       Serial_Data_In;
    logic [7:0] Parallel_Data_Out;
    logic       Data_Valid_Out;
    logic       Data_Ready_In;
    logic       Busy_Out;
    logic       Overrun_Out;
    logic       Clear_Overrun_In;
    modport master (
        output Frame_Start_In, Serial_Data_In, Data_Ready_In, Clear_Overrun_In,
        input  Parallel_Data_Out, Data_Valid_Out, Busy_Out, Overrun_Out
    );
    modport slave (
        input  Frame_Start_In, Serial_Data_In, Data_Ready_In, Clear_Overrun_In,
        output Parallel_Data_Out, Data_Valid_Out, Busy_Out, Overrun_Out
    );
endinterface

// File: rtl/sipo_deserializer_8_bit.sv
// sipo_deserializer_8_bit: 8-bit serial-to-parallel receiver with a one-byte holding register and sticky overrun.
module sipo_deserializer_8_bit #(
    parameter bit MSB_FIRST = 1'b1
) (
    input logic Clk_In,
    input logic Reset_In,
    sipo_deserializer_8_bit_if.slave bus
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;
    logic [0:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] sh_q, sh_d, dout_q, dout_d;
    logic       vld_q, vld_d, ovr_q, ovr_d;
    logic       start, sd, rdy, done, load, drop;
    assign start = bus.Frame_Start_In;
    assign sd    = bus.Serial_Data_In;
    assign rdy   = bus.Data_Ready_In;
    // A start pulse always wins, so a start on what would be bit 8 restarts instead of completing.
    assign done  = (state_q == SHIFT) && !start && (cnt_q == 4'd7);
    assign load  = done && (!vld_q || rdy);
    assign drop  = done && vld_q && !rdy;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        if (start) begin
            state_d = SHIFT;
            cnt_d   = 4'd1;
            sh_d    = MSB_FIRST ? {7'h00, sd} : {sd, 7'h00};
        end else if (state_q == SHIFT) begin
            state_d = done ? IDLE : SHIFT;
            cnt_d   = done ? 4'd0 : cnt_q + 4'd1;
            sh_d    = MSB_FIRST ? {sh_q[6:0], sd} : {sd, sh_q[7:1]};
        end
        dout_d = load ? sh_d : dout_q;
        vld_d  = load | (vld_q & ~rdy);
        ovr_d  = drop | (ovr_q & ~bus.Clear_Overrun_In);
    end
    always_ff @(posedge Clk_In or negedge Reset_In) begin
        if (!Reset_In) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            sh_q    <= 8'h00;
            dout_q  <= 8'h00;
            vld_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
            ovr_q   <= ovr_d;
        end
    end
    assign bus.Parallel_Data_Out = dout_q;
    assign bus.Data_Valid_Out    = vld_q;
    assign bus.Busy_Out          = (state_q == SHIFT);
    assign bus.Overrun_Out       = ovr_q;
endmodule

// File: tb/tb_sipo_deserializer_8_bit.sv
// tb_sipo_deserializer_8_bit: directed table plus hand sequences for both bit orders of the deserializer.
module tb_sipo_deserializer_8_bit;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    sipo_deserializer_8_bit_if m_if ();
    sipo_deserializer_8_bit_if l_if ();
    sipo_deserializer_8_bit #(.MSB_FIRST(1'b1)) u_msb (.Clk_In(clk), .Reset_In(rst_n), .bus(m_if));
    sipo_deserializer_8_bit #(.MSB_FIRST(1'b0)) u_lsb (.Clk_In(clk), .Reset_In(rst_n), .bus(l_if));
    assign l_if.Frame_Start_In   = m_if.Frame_Start_In;
    assign l_if.Serial_Data_In   = m_if.Serial_Data_In;
    assign l_if.Data_Ready_In    = 1'b1;
    assign l_if.Clear_Overrun_In = 1'b0;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    typedef struct {
        logic [7:0] data;
        logic       rdy;
        logic [7:0] exp_lsb;
    } vec_t;
    vec_t vecs [6];
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    // Bits go out in transmission order: b[7] first, start pulse on the first bit.
    task automatic send_frame(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            m_if.Frame_Start_In = (i == 0);
            m_if.Serial_Data_In = b[7-i];
        end
    endtask
    task automatic drain();
        m_if.Data_Ready_In = 1'b1;
        @(negedge clk);
        m_if.Frame_Start_In = 1'b0;
    endtask
    initial begin
        n_cmp = 0;
        n_err = 0;
        vecs[0] = '{8'hA5, 1'b1, 8'hA5};
        vecs[1] = '{8'h3C, 1'b0, 8'h3C};
        vecs[2] = '{8'hC3, 1'b1, 8'hC3};
        vecs[3] = '{8'h00, 1'b1, 8'h00};
        vecs[4] = '{8'hF0, 1'b0, 8'h0F};
        vecs[5] = '{8'h81, 1'b1, 8'h81};
        rst_n = 1'b0;
        m_if.Frame_Start_In   = 1'b0;
        m_if.Serial_Data_In   = 1'b1;
        m_if.Data_Ready_In    = 1'b0;
        m_if.Clear_Overrun_In = 1'b0;
        #1;
        chk("rst_dout", m_if.Parallel_Data_Out, 8'h00);
        chk("rst_vld", {7'd0, m_if.Data_Valid_Out}, 8'h00);
        chk("rst_busy", {7'd0, m_if.Busy_Out}, 8'h00);
        chk("rst_ovr", {7'd0, m_if.Overrun_Out}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_vld", {7'd0, m_if.Data_Valid_Out}, 8'h00);
        for (int v = 0; v < 6; v++) begin
            drain();
            chk("tbl_empty", {7'd0, m_if.Data_Valid_Out}, 8'h00);
            m_if.Data_Ready_In = vecs[v].rdy;
            send_frame(vecs[v].data);
            @(negedge clk);
            m_if.Serial_Data_In = 1'b0;
            chk("tbl_dout", m_if.Parallel_Data_Out, vecs[v].data);
            chk("tbl_vld", {7'd0, m_if.Data_Valid_Out}, 8'h01);
            chk("tbl_busy", {7'd0, m_if.Busy_Out}, 8'h00);
            chk("tbl_ovr", {7'd0, m_if.Overrun_Out}, 8'h00);
            chk("tbl_lsb", l_if.Parallel_Data_Out, vecs[v].exp_lsb);
        end
        drain();
        m_if.Data_Ready_In = 1'b0;
        send_frame(8'h3C);
        send_frame(8'hC3);
        @(negedge clk);
        chk("b2b_dout", m_if.Parallel_Data_Out, 8'h3C);
        chk("b2b_ovr", {7'd0, m_if.Overrun_Out}, 8'h01);
        for (int i = 0; i < 3; i++) @(negedge clk);
        chk("hold_dout", m_if.Parallel_Data_Out, 8'h3C);
        chk("hold_vld", {7'd0, m_if.Data_Valid_Out}, 8'h01);
        m_if.Data_Ready_In = 1'b1;
        @(negedge clk);
        m_if.Data_Ready_In = 1'b0;
        chk("accept_vld", {7'd0, m_if.Data_Valid_Out}, 8'h00);
        m_if.Clear_Overrun_In = 1'b1;
        @(negedge clk);
        m_if.Clear_Overrun_In = 1'b0;
        chk("clr_ovr", {7'd0, m_if.Overrun_Out}, 8'h00);
        send_frame(8'h11);
        send_frame(8'h22);
        m_if.Clear_Overrun_In = 1'b1;
        @(negedge clk);
        chk("setwin_ovr", {7'd0, m_if.Overrun_Out}, 8'h01);
        chk("setwin_dout", m_if.Parallel_Data_Out, 8'h11);
        @(negedge clk);
        m_if.Clear_Overrun_In = 1'b0;
        chk("clr2_ovr", {7'd0, m_if.Overrun_Out}, 8'h00);
        send_frame(8'h99);
        m_if.Data_Ready_In = 1'b1;
        @(negedge clk);
        chk("swap_dout", m_if.Parallel_Data_Out, 8'h99);
        chk("swap_vld", {7'd0, m_if.Data_Valid_Out}, 8'h01);
        chk("swap_ovr", {7'd0, m_if.Overrun_Out}, 8'h00);
        @(negedge clk);
        chk("swap_drain", {7'd0, m_if.Data_Valid_Out}, 8'h00);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            m_if.Frame_Start_In = (i == 0);
            m_if.Serial_Data_In = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("part_busy", {7'd0, m_if.Busy_Out}, 8'h01);
        send_frame(8'h5A);
        @(negedge clk);
        chk("restart_dout", m_if.Parallel_Data_Out, 8'h5A);
        chk("restart_vld", {7'd0, m_if.Data_Valid_Out}, 8'h01);
        chk("restart_ovr", {7'd0, m_if.Overrun_Out}, 8'h00);
        m_if.Data_Ready_In = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            m_if.Frame_Start_In = (i == 0);
            m_if.Serial_Data_In = 1'b1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_dout", m_if.Parallel_Data_Out, 8'h00);
        chk("mrst_vld", {7'd0, m_if.Data_Valid_Out}, 8'h00);
        chk("mrst_busy", {7'd0, m_if.Busy_Out}, 8'h00);
        chk("mrst_ovr", {7'd0, m_if.Overrun_Out}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        m_if.Frame_Start_In = 1'b0;
        m_if.Data_Ready_In = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            m_if.Serial_Data_In = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        chk("post_vld", {7'd0, m_if.Data_Valid_Out}, 8'h00);
        chk("post_busy", {7'd0, m_if.Busy_Out}, 8'h00);
        send_frame(8'hC3);
        @(negedge clk);
        chk("post_dout", m_if.Parallel_Data_Out, 8'hC3);
        chk("post_vld2", {7'd0, m_if.Data_Valid_Out}, 8'h01);
        send_frame(8'h80);
        @(negedge clk);
        chk("msb_80", m_if.Parallel_Data_Out, 8'h80);
        chk("lsb_01", l_if.Parallel_Data_Out, 8'h01);
        chk("lsb_vld", {7'd0, l_if.Data_Valid_Out}, 8'h01);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sipo_deserializer_8_bit.md
SIPO_DESERIALIZER_8_BIT -- requirements
Module: sipo_deserializer_8_bit

Interface
REQ-001 Parameter MSB_FIRST, default 1, selects bit order: 1 means the first received bit lands in Parallel_Data_Out[7]; 0 means it lands in [0].
REQ-002 Clk_In  input  1  single clock; all state updates on its rising edge.
REQ-003 Reset_In  input  1  asynchronous, active-low reset (0 = reset).
REQ-004 Frame_Start_In  input  1  high for exactly the cycle carrying the first bit of a frame.
REQ-005 Serial_Data_In  input  1  serial bit, sampled every cycle while receiving.
REQ-006 Parallel_Data_Out  output  8  assembled byte in the output holding register.
REQ-007 Data_Valid_Out  output  1  holding register contains an unconsumed byte.
REQ-008 Data_Ready_In  input  1  consumer accepts the byte in any cycle where Data_Valid_Out=1 and Data_Ready_In=1.
REQ-009 Busy_Out  output  1  frame reception in progress (state SHIFT).
REQ-010 Overrun_Out  output  1  sticky flag: a completed byte was dropped.
REQ-011 Clear_Overrun_In  input  1  synchronous clear of Overrun_Out.

Function
REQ-012 The FSM SHALL have two states, IDLE and SHIFT, plus a 4-bit bit counter and an 8-bit internal shift register separate from the output holding register.
REQ-013 In IDLE with Frame_Start_In=1, the block SHALL sample Serial_Data_In as frame bit 1, set the counter to 1, and go to SHIFT; with Frame_Start_In=0 it SHALL stay in IDLE.
REQ-014 In SHIFT, the block SHALL sample one bit per cycle and shift it in per MSB_FIRST. A frame is exactly 8 consecutive cycles, starting with the Frame_Start_In cycle.
REQ-015 The edge that samples bit 8 SHALL complete the frame, return the FSM to IDLE, and reset the counter to 0.
REQ-016 The completed byte SHALL appear on Parallel_Data_Out with Data_Valid_Out=1 from the cycle after bit 8 (latency 1 cycle after the last bit), provided the holding register is empty or being accepted in that cycle.
REQ-017 Frame_Start_In may be asserted in the cycle immediately after bit 8: back-to-back frames with zero gap SHALL be received without loss.
REQ-018 Frame_Start_In=1 while in SHIFT before bit 8 SHALL discard the partial frame and restart with the current bit as bit 1; no flag is set and no byte is output.
REQ-019 Data_Valid_Out SHALL stay high, and Parallel_Data_Out SHALL stay stable, until a cycle with Data_Ready_In=1; after such a cycle Data_Valid_Out SHALL fall, unless a new byte completes in that same cycle.
REQ-020 If a byte completes while Data_Valid_Out=1 and Data_Ready_In=0, the new byte SHALL be dropped, the held byte kept, and Overrun_Out set to 1.
REQ-021 If a byte completes in the same cycle the held byte is accepted, the new byte SHALL replace it, Data_Valid_Out SHALL stay 1, and no overrun is flagged.
REQ-022 Clear_Overrun_In=1 SHALL clear Overrun_Out at the next edge; if an overrun occurs in that same cycle, set SHALL win.
REQ-023 Busy_Out SHALL equal 1 exactly while the FSM is in SHIFT.
REQ-024 Serial_Data_In SHALL be ignored in IDLE when Frame_Start_In=0.

Reset
REQ-025 Reset_In=0 SHALL immediately, without waiting for a clock edge, force: FSM=IDLE, counter=0, shift register=8'h00, Parallel_Data_Out=8'h00, Data_Valid_Out=0, Busy_Out=0, Overrun_Out=0.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame; a held, unaccepted byte SHALL also be discarded.
REQ-027 After Reset_In returns to 1, the first Frame_Start_In sampled at a rising edge SHALL start a frame normally.

Verification
REQ-028 MSB_FIRST=1, Data_Ready_In=1, Frame_Start_In with bits 1,0,1,0,0,1,0,1 -> one cycle after bit 8: Data_Valid_Out=1, Parallel_Data_Out=8'hA5, Busy_Out=0.
REQ-029 Back-to-back frames 8'h3C then 8'hC3 with Data_Ready_In=0 -> Parallel_Data_Out stays 8'h3C and Overrun_Out=1; then Data_Ready_In=1 for one cycle -> Data_Valid_Out=0.
REQ-030 Frame_Start_In re-asserted after 4 bits, then bits of 8'h5A -> only 8'h5A is output, Overrun_Out=0.
REQ-031 Reset_In=0 during bit 5 -> all outputs zero before the next edge; after release, no Data_Valid_Out until a new frame completes.
REQ-032 MSB_FIRST=0, bits 1,0,0,0,0,0,0,0 -> Parallel_Data_Out=8'h01.
REQ-033 Clear_Overrun_In=1 in the same cycle as a new overrun -> Overrun_Out remains 1; Clear_Overrun_In=1 alone -> Overrun_Out=0 at the next edge.
